// File: rtl/qam16_tx_mapper.sv
// qam16_tx_mapper: packs a serial bit stream into 4-bit symbols and maps
// them to Gray-coded QAM16 I/Q levels. Each symbol is emitted as one
// non-zero sample followed by SPS-1 zero samples for the shaping filter.
// With DIFF_EN the quadrant is differentially encoded against the last
// transmitted quadrant, which is cleared only by reset.
module qam16_tx_mapper #(
  parameter int SPS     = 8,
  parameter bit DIFF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic signed [2:0] di,
  output logic signed [2:0] dq,
  output logic              sym_stb,
  output logic              underflow
);

  localparam int            CW        = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] SCNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] SCNT_ONE  = CW'(1);
  localparam logic [CW-1:0] SCNT_LAST = CW'(SPS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [CW-1:0]       scnt_r, scnt_s;
  logic [1:0]          bitcnt_r;
  logic [2:0]          shreg_r;
  logic [3:0]          hold_r;
  logic                hold_full_r;
  logic [1:0]          qprev_r;
  logic [1:0]          qt_s;
  logic                xfer_s, last_bit_s, load_s, unf_s;
  logic signed [2:0]   di_s, dq_s;

  // Gray pair to amplitude: 00->-3, 01->-1, 11->+1, 10->+3
  function automatic logic signed [2:0] gray_level(input logic [1:0] g);
    case (g)
      2'b00:   gray_level = 3'sb101;
      2'b01:   gray_level = 3'sb111;
      2'b11:   gray_level = 3'sb001;
      2'b10:   gray_level = 3'sb011;
      default: gray_level = 3'sb000;
    endcase
  endfunction

  // Gray pair to quadrant step: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gray_quad(input logic [1:0] g);
    case (g)
      2'b00:   gray_quad = 2'd0;
      2'b01:   gray_quad = 2'd1;
      2'b11:   gray_quad = 2'd2;
      2'b10:   gray_quad = 2'd3;
      default: gray_quad = 2'd0;
    endcase
  endfunction

  // Magnitude bit (0 -> 3, 1 -> 1) with sign applied
  function automatic logic signed [2:0] signed_mag(input logic mbit, input logic neg);
    case ({neg, mbit})
      2'b00:   signed_mag = 3'sb011;
      2'b01:   signed_mag = 3'sb001;
      2'b10:   signed_mag = 3'sb101;
      2'b11:   signed_mag = 3'sb111;
      default: signed_mag = 3'sb000;
    endcase
  endfunction

  assign din_rdy    = !((bitcnt_r == 2'd3) && hold_full_r);
  assign xfer_s     = din_vld && din_rdy;
  assign last_bit_s = xfer_s && (bitcnt_r == 2'd3);

  // Symbol-slot sequencing: IDLE waits for a held symbol, RUN paces slots
  always_comb begin
    state_s = state_r;
    scnt_s  = scnt_r;
    load_s  = 1'b0;
    unf_s   = 1'b0;
    case (state_r)
      IDLE: begin
        scnt_s = SCNT_ZERO;
        if (hold_full_r) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (scnt_r == SCNT_LAST) begin
          scnt_s = SCNT_ZERO;
        end else begin
          scnt_s = scnt_r + SCNT_ONE;
        end
        if (scnt_r == SCNT_ZERO) begin
          if (hold_full_r) begin
            load_s = 1'b1;
          end else begin
            unf_s   = 1'b1;
            state_s = IDLE;
            scnt_s  = SCNT_ZERO;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        scnt_s  = SCNT_ZERO;
      end
    endcase
  end

  // Map the held symbol to I/Q (differential quadrant or absolute Gray)
  always_comb begin
    qt_s = qprev_r + gray_quad({hold_r[3], hold_r[1]});
    di_s = 3'sb000;
    dq_s = 3'sb000;
    if (DIFF_EN) begin
      // Odd quadrants swap which data bit sets the I and Q magnitudes
      if (qt_s[0]) begin
        di_s = signed_mag(hold_r[0], qt_s[1] ^ qt_s[0]);
        dq_s = signed_mag(hold_r[2], qt_s[1]);
      end else begin
        di_s = signed_mag(hold_r[2], qt_s[1] ^ qt_s[0]);
        dq_s = signed_mag(hold_r[0], qt_s[1]);
      end
    end else begin
      di_s = gray_level(hold_r[3:2]);
      dq_s = gray_level(hold_r[1:0]);
    end
  end

  // Shift incoming bits (b3 first); counter wraps after the 4th bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt_r <= 2'd0;
      shreg_r  <= 3'd0;
    end else if (xfer_s) begin
      bitcnt_r <= bitcnt_r + 2'd1;
      shreg_r  <= {shreg_r[1:0], din};
    end
  end

  // Hold register: a completed symbol write wins over a same-cycle load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_r      <= 4'd0;
      hold_full_r <= 1'b0;
    end else if (last_bit_s) begin
      hold_r      <= {shreg_r, din};
      hold_full_r <= 1'b1;
    end else if (load_s) begin
      hold_full_r <= 1'b0;
    end
  end

  // FSM state and slot counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      scnt_r  <= SCNT_ZERO;
    end else begin
      state_r <= state_s;
      scnt_r  <= scnt_s;
    end
  end

  // Registered outputs and quadrant memory (survives IDLE)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      di        <= 3'sb000;
      dq        <= 3'sb000;
      sym_stb   <= 1'b0;
      underflow <= 1'b0;
      qprev_r   <= 2'd0;
    end else begin
      di        <= load_s ? di_s : 3'sb000;
      dq        <= load_s ? dq_s : 3'sb000;
      sym_stb   <= load_s;
      underflow <= unf_s;
      if (load_s) begin
        qprev_r <= qt_s;
      end
    end
  end

endmodule

// File: tb/tb_qam16_tx_mapper.sv
// Bench for qam16_tx_mapper: one absolute-mapping and one differential
// instance share the same stimulus; an integer model predicts every output
// each cycle, and directed tests pin literal values and timing.
module tb_qam16_tx_mapper;
  localparam int SPS = 8;

  logic clk = 1'b0;
  logic rst, din, din_vld;
  logic rdy0, rdy1, stb0, stb1, unf0, unf1;
  logic signed [2:0] di0, dq0, di1, dq1;

  always #5 clk = ~clk;

  qam16_tx_mapper #(.SPS(SPS), .DIFF_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(rdy0),
    .di(di0), .dq(dq0), .sym_stb(stb0), .underflow(unf0));

  qam16_tx_mapper #(.SPS(SPS), .DIFF_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(rdy1),
    .di(di1), .dq(dq1), .sym_stb(stb1), .underflow(unf1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int stall_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int lvl_tab[4]  = '{-3, -1, 3, 1};   // index = 2-bit Gray pair value
  int quad_tab[4] = '{0, 1, 3, 2};

  function automatic void map_abs(input int s, output int i, output int q);
    i = lvl_tab[(s >> 2) & 3];
    q = lvl_tab[s & 3];
  endfunction

  function automatic void map_diff(input int s, input int qp, output int i, output int q, output int qt);
    int b3, b2, b1, b0, mi, mq;
    b3 = (s >> 3) & 1; b2 = (s >> 2) & 1; b1 = (s >> 1) & 1; b0 = s & 1;
    qt = (qp + quad_tab[b3 * 2 + b1]) % 4;
    if (qt % 2 == 0) begin
      mi = b2 ? 1 : 3; mq = b0 ? 1 : 3;
    end else begin
      mi = b0 ? 1 : 3; mq = b2 ? 1 : 3;
    end
    i = (qt == 1 || qt == 2) ? -mi : mi;
    q = (qt >= 2) ? -mq : mq;
  endfunction

  int m_bits, m_acc, m_hold, m_phase, m_qprev, m_qt;
  bit m_hold_v, m_run, m_rdy, m_xfer;
  int e_i0, e_q0, e_i1, e_q1;
  bit e_stb, e_unf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_bits = 0; m_acc = 0; m_hold = 0; m_hold_v = 0; m_run = 0;
      m_phase = 0; m_qprev = 0;
      e_i0 = 0; e_q0 = 0; e_i1 = 0; e_q1 = 0; e_stb = 0; e_unf = 0;
    end else begin
      m_rdy  = !(m_bits == 3 && m_hold_v);
      m_xfer = din_vld && m_rdy;
      e_stb = 0; e_unf = 0; e_i0 = 0; e_q0 = 0; e_i1 = 0; e_q1 = 0;
      if (!m_run) begin
        if (m_hold_v) begin m_run = 1; m_phase = 0; end
      end else if (m_phase == 0 && !m_hold_v) begin
        e_unf = 1; m_run = 0;
      end else begin
        if (m_phase == 0) begin
          map_abs(m_hold, e_i0, e_q0);
          map_diff(m_hold, m_qprev, e_i1, e_q1, m_qt);
          m_qprev = m_qt; m_hold_v = 0; e_stb = 1;
        end
        m_phase = (m_phase + 1) % SPS;
      end
      if (m_xfer) begin
        m_acc = m_acc * 2 + int'(din);
        m_bits++;
        if (m_bits == 4) begin
          m_hold = m_acc; m_hold_v = 1; m_bits = 0; m_acc = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare and capture ----------------
  int cap_i0[$], cap_q0[$], cap_i1[$], cap_q1[$], cap_cyc[$], unf_cyc[$];

  always @(negedge clk) begin
    chk("din_rdy0", rdy0, (m_bits == 3 && m_hold_v) ? 0 : 1);
    chk("din_rdy1", rdy1, (m_bits == 3 && m_hold_v) ? 0 : 1);
    chk("sym_stb0", stb0, e_stb);
    chk("sym_stb1", stb1, e_stb);
    chk("underflow0", unf0, e_unf);
    chk("underflow1", unf1, e_unf);
    chk("di_abs", int'(di0), e_i0);
    chk("dq_abs", int'(dq0), e_q0);
    chk("di_diff", int'(di1), e_i1);
    chk("dq_diff", int'(dq1), e_q1);
    if (din_vld && !rdy0) stall_seen++;
    if (stb0) begin
      cap_i0.push_back(int'(di0)); cap_q0.push_back(int'(dq0));
      cap_i1.push_back(int'(di1)); cap_q1.push_back(int'(dq1));
      cap_cyc.push_back(cyc);
    end
    if (unf0) unf_cyc.push_back(cyc);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bit(input logic b);
    int n = 0;
    din = b; din_vld = 1'b1;
    while (!rdy0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL rdy_timeout: din_rdy low for %0d clocks", n);
    end
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic send_sym(input int s);
    for (int k = 3; k >= 0; k--) send_bit(logic'((s >> k) & 1));
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_caps();
    cap_i0.delete(); cap_q0.delete(); cap_i1.delete(); cap_q1.delete();
    cap_cyc.delete(); unf_cyc.delete();
  endtask

  task automatic do_reset();
    din_vld = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_di", int'(di0), 0);
    chk("rst_dq", int'(dq1), 0);
    chk("rst_stb", stb1, 0);
    chk("rst_rdy", rdy0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic int gray_idx(input int v);
    for (int k = 0; k < 4; k++) if (lvl_tab[k] == v) return k;
    return 99;
  endfunction

  // ---------------- directed tests ----------------
  int ti, tq, tqt, a, acc3;
  int sent[$];

  initial begin
    rst = 1'b0; din = 1'b0; din_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_di", int'(di0), 0);
    chk("reset_stb", stb0, 0);
    chk("reset_unf", unf0, 0);
    chk("reset_rdy", rdy0, 1);
    rst = 1'b1;
    @(negedge clk);

    // pin the model against hand-computed values
    map_abs(11, ti, tq);          chk("pin_abs_i", ti, 3);  chk("pin_abs_q", tq, 1);
    map_diff(11, 0, ti, tq, tqt); chk("pin_d1_i", ti, -3);  chk("pin_d1_q", tq, -1);
    map_diff(4, tqt, ti, tq, tqt); chk("pin_d2_i", ti, -1); chk("pin_d2_q", tq, -3);
    map_diff(3, tqt, ti, tq, tqt); chk("pin_d3_i", ti, 1);  chk("pin_d3_q", tq, -3);

    // absolute mapping, single symbol 1011, then underflow
    clear_caps();
    send_sym(11); a = acc_cyc;
    idle(14);
    chk("t2_nsym", cap_cyc.size(), 1);
    chk("t2_nunf", unf_cyc.size(), 1);
    if (cap_cyc.size() >= 1 && unf_cyc.size() >= 1) begin
      chk("t2_latency", cap_cyc[0] - a, 2);
      chk("t2_di", cap_i0[0], 3);
      chk("t2_dq", cap_q0[0], 1);
      chk("t2_unf_gap", unf_cyc[0] - cap_cyc[0], 8);
    end

    // reset mid-run discards partial bits
    send_sym(5); send_bit(1'b1); send_bit(1'b1);
    do_reset();
    clear_caps();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    idle(12);
    chk("t1_no_sym_3bits", cap_cyc.size(), 0);
    send_bit(1'b0);
    idle(12);
    chk("t1_nsym", cap_cyc.size(), 1);
    if (cap_cyc.size() >= 1) begin
      chk("t1_di", cap_i0[0], -1);
      chk("t1_dq", cap_q0[0], 3);
    end

    // differential, back-to-back from qprev=0, with back-pressure on symbol 3
    do_reset();
    clear_caps();
    send_sym(11); send_sym(4); send_sym(3); acc3 = acc_cyc;
    idle(30);
    chk("t3_nsym", cap_cyc.size(), 3);
    if (cap_cyc.size() >= 3) begin
      chk("t3_s1_i", cap_i1[0], -3); chk("t3_s1_q", cap_q1[0], -1);
      chk("t3_s2_i", cap_i1[1], -1); chk("t3_s2_q", cap_q1[1], -3);
      chk("t3_s3_i", cap_i1[2], 1);  chk("t3_s3_q", cap_q1[2], -3);
      chk("t3_gap12", cap_cyc[1] - cap_cyc[0], 8);
      chk("t3_gap23", cap_cyc[2] - cap_cyc[1], 8);
      chk("t3_stalled_accept", acc3 - cap_cyc[1], 1);
    end

    // 100 random symbols with din_vld held high
    clear_caps();
    stall_seen = 0;
    for (int s = 0; s < 100; s++) begin
      sent.push_back(int'($urandom_range(0, 15)));
      send_sym(sent[s]);
    end
    idle(30);
    chk("t4_nsym", cap_cyc.size(), 100);
    chk("t4_backpressure_seen", (stall_seen > 0) ? 1 : 0, 1);
    if (cap_cyc.size() == 100) begin
      for (int s = 0; s < 100; s++)
        chk("t4_symbol", gray_idx(cap_i0[s]) * 4 + gray_idx(cap_q0[s]), sent[s]);
      for (int s = 1; s < 100; s++)
        chk("t4_spacing", cap_cyc[s] - cap_cyc[s-1], 8);
    end

    // stall for 20 clocks mid-stream, then recover
    clear_caps();
    send_sym(9); send_sym(6);
    idle(20);
    chk("t5_nsym", cap_cyc.size(), 2);
    chk("t5_nunf", unf_cyc.size(), 1);
    clear_caps();
    send_sym(12); a = acc_cyc;
    idle(12);
    chk("t5_nsym_after", cap_cyc.size(), 1);
    if (cap_cyc.size() >= 1) begin
      chk("t5_latency", cap_cyc[0] - a, 2);
      chk("t5_di", cap_i0[0], 1);
      chk("t5_dq", cap_q0[0], -3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
